am74ls139_seq: RTL

- Parametrised registered successor to the 2-to-4 decoder: SELW-bit select to 2^SELW active-low one-hot outputs.
- Adds an internal index register with hold/load/count-up/count-down modes, programmable wrap point and terminal-count flag.
- Serves as a microcycle phase generator or sequenced chip-select decoder next to the Am29xx slices.
- Also usable as a plain decoder: load mode every cycle gives a one-clock-latency decode.

---
 rtl/am74ls139_seq.sv | 82 ++++++++
 1 files changed

// File: rtl/am74ls139_seq.sv
// Registered one-hot-low decoder with an index register.
// The index can hold, load, count up or count down, with a programmable wrap point.
// A terminal-count flag warns that the next enabled edge will wrap.
module am74ls139_seq #(
  parameter int unsigned SELW = 2,
  parameter int unsigned LAST = (1 << SELW) - 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    g_n_i,
  input  logic [1:0]              mode_i,
  input  logic [SELW-1:0]         sel_i,
  output logic [(1 << SELW)-1:0]  y_o,
  output logic [SELW-1:0]         idx_o,
  output logic                    tc_o
);

  localparam int unsigned NOUT = 1 << SELW;
  localparam logic [SELW-1:0] LastIdx = LAST[SELW-1:0];

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeLoad = 2'b01,
    ModeUp   = 2'b10,
    ModeDown = 2'b11
  } mode_e;

  mode_e           mode;
  logic [SELW-1:0] idx_q, idx_d;

  assign mode  = mode_e'(mode_i);
  assign idx_o = idx_q;

  // Next index: only moves when enabled; an index above LastIdx wraps to 0 when counting up
  // and decrements normally when counting down.
  always_comb begin
    idx_d = idx_q;
    if (!g_n_i) begin
      unique case (mode)
        ModeHold: idx_d = idx_q;
        ModeLoad: idx_d = sel_i;
        ModeUp:   idx_d = (idx_q >= LastIdx) ? '0 : idx_q + 1'b1;
        ModeDown: idx_d = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
        default:  idx_d = idx_q;
      endcase
    end
  end

  // Index register; reset clears it immediately without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Decode: all outputs high unless enabled and out of reset, then only y[idx] is low.
  always_comb begin
    y_o = {NOUT{1'b1}};
    if (!g_n_i && !rst_i) begin
      for (int unsigned i = 0; i < NOUT; i++) begin
        if (idx_q == i[SELW-1:0]) begin
          y_o[i] = 1'b0;
        end
      end
    end
  end

  // Terminal count: the next enabled count edge wraps.
  always_comb begin
    tc_o = 1'b0;
    if (!g_n_i && !rst_i) begin
      unique case (mode)
        ModeUp:   tc_o = (idx_q >= LastIdx);
        ModeDown: tc_o = (idx_q == '0);
        default:  tc_o = 1'b0;
      endcase
    end
  end

endmodule
